pic_cpu_bus_master: RTL and testbench



---
 rtl/pic_cpu_bus_master_if.sv | 28 ++
 rtl/pic_cpu_bus_master.sv | 211 +++++++++++++++++++++
 tb/tb_pic_cpu_bus_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_cpu_bus_master_if.sv
// Bundle of the command/response handshake and the PIC CPU bus pins.
// master: the bus initiator's view. slave: the command source and PIC side.
interface pic_cpu_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;
    logic       A0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_a0, cmd_data, data_in,
        output cmd_ready, rsp_valid, rsp_data, CS_n, WR_n, RD_n, A0, data_out, data_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_a0, cmd_data, data_in,
        input  cmd_ready, rsp_valid, rsp_data, CS_n, WR_n, RD_n, A0, data_out, data_oe
    );
endinterface

// File: rtl/pic_cpu_bus_master.sv
// 8259 PIC CPU-bus initiator: turns single-beat commands into timed
// CS_n/WR_n/RD_n/A0 cycles. Define PIC_BUS_INIT_SEQ_EN to include the
// ICW1..ICW4 hardware initialization sequencer; without it the init
// inputs are ignored and init_busy/init_done stay 0.
module pic_cpu_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pic_cpu_bus_master_if.master        bus,
    input  logic                        init_start,
    input  logic [7:0]                  icw1,
    input  logic [7:0]                  icw2,
    input  logic [7:0]                  icw3,
    input  logic [7:0]                  icw4,
    output logic                        init_busy,
    output logic                        init_done
);
    localparam int unsigned Max1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MaxCyc = (Max1 > HOLD_CYC) ? Max1 : HOLD_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic [1:0] {CycIdle, CycSetup, CycStrobe, CycHold} cyc_state_e;

    cyc_state_e cyc_state;
    cnt_t       cnt;
    logic       cyc_write;

    logic       seq_req;
    logic       seq_a0;
    logic [7:0] seq_data;
    logic       init_accept;

    logic       cyc_idle;
    logic       start_cmd;
    logic       launch;
    logic       launch_write;
    logic       launch_a0;
    logic [7:0] launch_data;

    assign cyc_idle      = (cyc_state == CycIdle);
    // An accepted init_start takes priority over a same-cycle command.
    assign bus.cmd_ready = cyc_idle && !init_busy && !init_accept;
    assign start_cmd     = bus.cmd_valid && bus.cmd_ready;
    assign launch        = seq_req || start_cmd;
    assign launch_write  = seq_req ? 1'b1 : bus.cmd_write;
    assign launch_a0     = seq_req ? seq_a0 : bus.cmd_a0;
    assign launch_data   = seq_req ? seq_data : bus.cmd_data;

    // Bus cycle FSM: every phase loads N-1 into the down-counter and advances at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_state     <= CycIdle;
            cnt           <= '0;
            cyc_write     <= 1'b0;
            bus.CS_n      <= 1'b1;
            bus.WR_n      <= 1'b1;
            bus.RD_n      <= 1'b1;
            bus.A0        <= 1'b0;
            bus.data_out  <= 8'h00;
            bus.data_oe   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'h00;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (cyc_state)
                CycIdle: begin
                    if (launch) begin
                        cyc_state    <= CycSetup;
                        cnt          <= cnt_t'(SETUP_CYC - 1);
                        cyc_write    <= launch_write;
                        bus.CS_n     <= 1'b0;
                        bus.A0       <= launch_a0;
                        bus.data_out <= launch_data;
                        bus.data_oe  <= launch_write;
                    end
                end
                CycSetup: begin
                    if (cnt == '0) begin
                        cyc_state <= CycStrobe;
                        cnt       <= cnt_t'(STROBE_CYC - 1);
                        bus.WR_n  <= ~cyc_write;
                        bus.RD_n  <= cyc_write;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CycStrobe: begin
                    if (cnt == '0) begin
                        cyc_state <= CycHold;
                        cnt       <= cnt_t'(HOLD_CYC - 1);
                        bus.WR_n  <= 1'b1;
                        bus.RD_n  <= 1'b1;
                        // Read data is taken on the last strobe-low cycle.
                        if (!cyc_write) begin
                            bus.rsp_data <= bus.data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CycHold: begin
                    if (cnt == '0) begin
                        cyc_state     <= CycIdle;
                        bus.CS_n      <= 1'b1;
                        bus.data_oe   <= 1'b0;
                        bus.rsp_valid <= ~cyc_write;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PIC_BUS_INIT_SEQ_EN
    typedef enum logic [2:0] {
        InitIdle, InitIcw1, InitIcw2, InitIcw3, InitIcw4, InitDone
    } init_state_e;

    init_state_e init_state;
    init_state_e init_next;
    logic [7:0]  icw1_q, icw2_q, icw3_q, icw4_q;
    logic        launched;
    logic        hold_end;

    assign init_accept = init_start && !init_busy;
    assign hold_end    = (cyc_state == CycHold) && (cnt == '0);
    assign seq_req     = init_busy && cyc_idle && !launched;

    // Word and A0 for the current ICW, plus the following state with skips folded in.
    always_comb begin
        seq_data  = 8'h00;
        seq_a0    = 1'b1;
        init_next = init_state;
        unique case (init_state)
            InitIcw1: begin
                seq_data  = icw1_q | 8'h10;
                seq_a0    = 1'b0;
                init_next = InitIcw2;
            end
            InitIcw2: begin
                seq_data  = icw2_q;
                init_next = !icw1_q[1] ? InitIcw3 : (icw1_q[0] ? InitIcw4 : InitDone);
            end
            InitIcw3: begin
                seq_data  = icw3_q;
                init_next = icw1_q[0] ? InitIcw4 : InitDone;
            end
            InitIcw4: begin
                seq_data  = icw4_q;
                init_next = InitDone;
            end
            default: ;
        endcase
    end

    // Init sequencer: one write per ICW state, advancing when that write's hold ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_state <= InitIdle;
            icw1_q     <= 8'h00;
            icw2_q     <= 8'h00;
            icw3_q     <= 8'h00;
            icw4_q     <= 8'h00;
            launched   <= 1'b0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
        end else if (init_accept) begin
            init_state <= InitIcw1;
            icw1_q     <= icw1;
            icw2_q     <= icw2;
            icw3_q     <= icw3;
            icw4_q     <= icw4;
            launched   <= 1'b0;
            init_busy  <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            unique case (init_state)
                InitIcw1, InitIcw2, InitIcw3, InitIcw4: begin
                    if (seq_req) begin
                        launched <= 1'b1;
                    end else if (launched && hold_end) begin
                        launched   <= 1'b0;
                        init_state <= init_next;
                        if (init_next == InitDone) begin
                            init_busy <= 1'b0;
                            init_done <= 1'b1;
                        end
                    end
                end
                InitDone: init_state <= InitIdle;
                default:  init_state <= InitIdle;
            endcase
        end
    end
`else
    logic unused_init;

    assign unused_init = ^{init_start, icw1, icw2, icw3, icw4};
    assign init_accept = 1'b0;
    assign seq_req     = 1'b0;
    assign seq_a0      = 1'b0;
    assign seq_data    = 8'h00;
    assign init_busy   = 1'b0;
    assign init_done   = 1'b0;
`endif
endmodule

// File: tb/tb_pic_cpu_bus_master.sv
// Directed bench for pic_cpu_bus_master: default-timing instance plus a
// SETUP=2/STROBE=3/HOLD=2 instance. Init tests run when PIC_BUS_INIT_SEQ_EN is defined.
module tb_pic_cpu_bus_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_cpu_bus_master_if bus ();
    pic_cpu_bus_master_if bus2 ();

    logic       init_start, init_start2;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       init_busy, init_done, init_busy2, init_done2;

    int checks = 0;
    int errors = 0;

    logic [7:0] cs_tr, wr_tr, rd_tr, oe_tr, rv_tr;
    logic       rv_any;
    int         nwr;
    logic [8:0] wr_log [4];
    logic       prev_wr;
    logic       ready_busy;

    pic_cpu_bus_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_start (init_start),
        .icw1       (icw1),
        .icw2       (icw2),
        .icw3       (icw3),
        .icw4       (icw4),
        .init_busy  (init_busy),
        .init_done  (init_done)
    );

    pic_cpu_bus_master #(
        .SETUP_CYC  (2),
        .STROBE_CYC (3),
        .HOLD_CYC   (2)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus2),
        .init_start (init_start2),
        .icw1       (icw1),
        .icw2       (icw2),
        .icw3       (icw3),
        .icw4       (icw4),
        .init_busy  (init_busy2),
        .init_done  (init_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample n cycles starting now; the PIC side answers reads while RD_n is low.
    task automatic trace(input bit sel, input int n);
        cs_tr = '0; wr_tr = '0; rd_tr = '0; oe_tr = '0; rv_tr = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            if (!sel) begin
                cs_tr[i[2:0]] = bus.CS_n;
                wr_tr[i[2:0]] = bus.WR_n;
                rd_tr[i[2:0]] = bus.RD_n;
                oe_tr[i[2:0]] = bus.data_oe;
                rv_tr[i[2:0]] = bus.rsp_valid;
                bus.data_in   = bus.RD_n ? 8'hEE : 8'h5A;
            end else begin
                cs_tr[i[2:0]] = bus2.CS_n;
                wr_tr[i[2:0]] = bus2.WR_n;
                rd_tr[i[2:0]] = bus2.RD_n;
                oe_tr[i[2:0]] = bus2.data_oe;
                rv_tr[i[2:0]] = bus2.rsp_valid;
                bus2.data_in  = bus2.RD_n ? 8'hC3 : 8'h3C;
            end
        end
    endtask

    // Log every write strobe on the default bus until init_done or a cycle budget runs out.
    task automatic watch_init();
        nwr = 0;
        prev_wr = 1'b1;
        ready_busy = 1'b0;
        for (int k = 0; k < 4; k++) wr_log[k] = '0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (init_done) break;
            if (bus.cmd_ready && init_busy) ready_busy = 1'b1;
            if (!bus.WR_n && prev_wr && nwr < 4) begin
                wr_log[nwr] = {bus.A0, bus.data_out};
                nwr++;
            end
            prev_wr = bus.WR_n;
        end
    endtask

    initial begin
        init_start = 1'b0; init_start2 = 1'b0;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_a0 = 1'b0;
        bus.cmd_data = 8'h00; bus.data_in = 8'h00;
        bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_a0 = 1'b0;
        bus2.cmd_data = 8'h00; bus2.data_in = 8'h00;

        // Reset values
        #12;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
        check("rst_strobes", 32'({bus.CS_n, bus.WR_n, bus.RD_n}), 32'h7);
        check("rst_a0_oe", 32'({bus.A0, bus.data_oe}), 32'h0);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_init", 32'({init_busy, init_done}), 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // Write with default timing
        bus.cmd_write = 1'b1; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'hFB; bus.cmd_valid = 1'b1;
        check("wr_ready_before", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("wr_ready_busy", 32'(bus.cmd_ready), 32'd0);
        check("wr_a0", 32'(bus.A0), 32'd1);
        check("wr_data_out", 32'(bus.data_out), 32'hFB);
        trace(1'b0, 5);
        check("wr_cs_trace", 32'(cs_tr), 32'h10);
        check("wr_wr_trace", 32'(wr_tr), 32'h19);
        check("wr_rd_trace", 32'(rd_tr), 32'h1F);
        check("wr_oe_trace", 32'(oe_tr), 32'h0F);
        check("wr_no_rsp", 32'(rv_tr), 32'h00);
        check("wr_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Read with default timing
        bus.cmd_write = 1'b0; bus.cmd_a0 = 1'b0; bus.cmd_data = 8'h00; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_a0", 32'(bus.A0), 32'd0);
        trace(1'b0, 5);
        check("rd_cs_trace", 32'(cs_tr), 32'h10);
        check("rd_rd_trace", 32'(rd_tr), 32'h19);
        check("rd_wr_trace", 32'(wr_tr), 32'h1F);
        check("rd_oe_trace", 32'(oe_tr), 32'h00);
        check("rd_rsp_trace", 32'(rv_tr), 32'h10);
        check("rd_rsp_data", 32'(bus.rsp_data), 32'h5A);
        tick();
        check("rd_rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
        check("rd_rsp_data_hold", 32'(bus.rsp_data), 32'h5A);

        // Reset in the middle of a write strobe
        bus.cmd_write = 1'b1; bus.cmd_a0 = 1'b0; bus.cmd_data = 8'h81; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("rstmid_in_strobe", 32'(bus.WR_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_outputs", 32'({bus.CS_n, bus.WR_n, bus.data_oe}), 32'h6);
        #2 rst_n = 1'b1;
        rv_any = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            rv_any = rv_any | bus.rsp_valid | ~bus.CS_n;
        end
        check("rstmid_no_rsp_no_cs", 32'(rv_any), 32'd0);
        check("rstmid_ready", 32'(bus.cmd_ready), 32'd1);

`ifdef PIC_BUS_INIT_SEQ_EN
        // Init: single, IC4 -> ICW1, ICW2, ICW4; also init beats a same-cycle command
        icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'h77; icw4 = 8'h03;
        bus.cmd_write = 1'b1; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'hEE; bus.cmd_valid = 1'b1;
        init_start = 1'b1;
        check("init1_init_wins", 32'(bus.cmd_ready), 32'd0);
        check("init1_busy_before", 32'(init_busy), 32'd0);
        tick();
        init_start = 1'b0; bus.cmd_valid = 1'b0;
        check("init1_busy_rise", 32'(init_busy), 32'd1);
        watch_init();
        check("init1_done", 32'({init_done, init_busy}), 32'h2);
        check("init1_nwr", 32'(nwr), 32'd3);
        check("init1_w0", 32'(wr_log[0]), 32'h013);
        check("init1_w1", 32'(wr_log[1]), 32'h120);
        check("init1_w2", 32'(wr_log[2]), 32'h103);
        check("init1_ready_busy", 32'(ready_busy), 32'd0);

        // Init: cascade, no IC4 -> ICW1, ICW2, ICW3; inputs changed mid-run are ignored
        tick();
        icw1 = 8'h00; icw2 = 8'h40; icw3 = 8'h04; icw4 = 8'h99;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        icw2 = 8'hAA; icw3 = 8'hBB;
        check("init2_done_cleared", 32'(init_done), 32'd0);
        watch_init();
        check("init2_done", 32'({init_done, init_busy}), 32'h2);
        check("init2_nwr", 32'(nwr), 32'd3);
        check("init2_w0", 32'(wr_log[0]), 32'h010);
        check("init2_w1", 32'(wr_log[1]), 32'h140);
        check("init2_w2", 32'(wr_log[2]), 32'h104);
        check("init2_ready_busy", 32'(ready_busy), 32'd0);
`else
        // Without the sequencer, init_start is ignored and the command proceeds
        bus.cmd_write = 1'b1; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'h22; bus.cmd_valid = 1'b1;
        init_start = 1'b1; icw1 = 8'h13;
        check("noinit_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        init_start = 1'b0; bus.cmd_valid = 1'b0;
        check("noinit_cmd_taken", 32'({bus.CS_n, bus.data_out}), 32'h022);
        check("noinit_busy", 32'(init_busy), 32'd0);
        for (int c = 0; c < 4; c++) tick();
        check("noinit_flags", 32'({init_busy, init_done}), 32'h0);
        check("noinit_idle", 32'(bus.CS_n), 32'd1);
`endif

        // Stretched timing: SETUP=2, STROBE=3, HOLD=2
        bus2.cmd_write = 1'b0; bus2.cmd_a0 = 1'b1; bus2.cmd_valid = 1'b1;
        tick();
        bus2.cmd_valid = 1'b0;
        trace(1'b1, 8);
        check("p2_cs_trace", 32'(cs_tr), 32'h80);
        check("p2_rd_trace", 32'(rd_tr), 32'hE3);
        check("p2_wr_trace", 32'(wr_tr), 32'hFF);
        check("p2_rsp_trace", 32'(rv_tr), 32'h80);
        check("p2_rsp_data", 32'(bus2.rsp_data), 32'h3C);
        tick();

`ifdef PIC_BUS_INIT_SEQ_EN
        icw1 = 8'h12; icw2 = 8'h08;
        bus2.cmd_write = 1'b1; bus2.cmd_valid = 1'b1;
        init_start2 = 1'b1;
        check("p2_init_wins", 32'(bus2.cmd_ready), 32'd0);
        tick();
        init_start2 = 1'b0; bus2.cmd_valid = 1'b0;
        check("p2_init_busy", 32'({init_busy2, bus2.CS_n}), 32'h3);
        for (int c = 0; c < 80; c++) begin
            tick();
            if (init_done2) break;
        end
        check("p2_init_done", 32'(init_done2), 32'd1);
`else
        bus2.cmd_write = 1'b1; bus2.cmd_valid = 1'b1;
        init_start2 = 1'b1;
        check("p2_noinit_ready", 32'(bus2.cmd_ready), 32'd1);
        tick();
        init_start2 = 1'b0; bus2.cmd_valid = 1'b0;
        check("p2_noinit_cmd", 32'({bus2.CS_n, bus2.data_oe}), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
